// File: rtl/bit_packer.sv
// Packs a 1-bit Mealy output stream into W-bit words behind a 2-entry valid/ready buffer.
// Optional per-word parity output enabled by defining BIT_PACKER_PARITY_EN.
module bit_packer #(
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     cont_in,
  output logic [W-1:0]             word_out,
  output logic [$clog2(W+1)-1:0]   word_nbits,
  output logic                     word_last,
  output logic                     word_valid,
  input  logic                     word_ready,
`ifdef BIT_PACKER_PARITY_EN
  output logic                     word_par,
`endif
  output logic                     overflow
);

  localparam int CW = $clog2(W+1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            head_q, head_d;
  logic [1:0]      count_q, count_d;
  logic [W-1:0]    word_mem_q [2];
  logic [W-1:0]    word_mem_d [2];
  logic [CW-1:0]   nbits_mem_q [2];
  logic [CW-1:0]   nbits_mem_d [2];
  logic            last_mem_q [2];
  logic            last_mem_d [2];
`ifdef BIT_PACKER_PARITY_EN
  logic            par_mem_q [2];
  logic            par_mem_d [2];
`endif

  logic            pop, full, push, tail;
  logic [W-1:0]    push_word;
  logic [CW-1:0]   push_nbits;
  logic            push_last;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    word_mem_d  = word_mem_q;
    nbits_mem_d = nbits_mem_q;
    last_mem_d  = last_mem_q;
`ifdef BIT_PACKER_PARITY_EN
    par_mem_d   = par_mem_q;
`endif
    push        = 1'b0;
    push_word   = '0;
    push_nbits  = '0;
    push_last   = 1'b0;
    pop         = (count_q != 2'd0) && word_ready;
    full        = (count_q == 2'd2);

    case (state_q)
      S_RUN: begin
        // A falling continue flag wins over any bit presented in the same cycle.
        if (!cont_in) begin
          state_d = S_FLUSH;
        end else if (bit_valid) begin
          sr_d  = {sr_q[W-2:0], bit_in};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W-1)) begin
            sr_d  = '0;
            cnt_d = '0;
            if (full && !pop) begin
              ovf_d = 1'b1;
            end else begin
              push       = 1'b1;
              push_word  = {sr_q[W-2:0], bit_in};
              push_nbits = CW'(W);
            end
          end
        end
      end
      S_FLUSH: begin
        // The final word must never be lost, so wait for room instead of dropping.
        if (!full || pop) begin
          push       = 1'b1;
          push_word  = sr_q << (W - int'(cnt_q));
          push_nbits = cnt_q;
          push_last  = 1'b1;
          state_d    = S_DONE;
        end
      end
      default: ;
    endcase

    // With two slots the tail is the head when empty or full, the other slot otherwise.
    tail = head_q ^ count_q[0];
    if (push) begin
      word_mem_d[tail]  = push_word;
      nbits_mem_d[tail] = push_nbits;
      last_mem_d[tail]  = push_last;
`ifdef BIT_PACKER_PARITY_EN
      par_mem_d[tail]   = ^push_word;
`endif
    end
    head_d  = head_q ^ pop;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      sr_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      head_q      <= 1'b0;
      count_q     <= 2'd0;
      word_mem_q  <= '{default: '0};
      nbits_mem_q <= '{default: '0};
      last_mem_q  <= '{default: 1'b0};
`ifdef BIT_PACKER_PARITY_EN
      par_mem_q   <= '{default: 1'b0};
`endif
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      head_q      <= head_d;
      count_q     <= count_d;
      word_mem_q  <= word_mem_d;
      nbits_mem_q <= nbits_mem_d;
      last_mem_q  <= last_mem_d;
`ifdef BIT_PACKER_PARITY_EN
      par_mem_q   <= par_mem_d;
`endif
    end
  end

  assign word_valid = (count_q != 2'd0);
  assign word_out   = word_valid ? word_mem_q[head_q]  : '0;
  assign word_nbits = word_valid ? nbits_mem_q[head_q] : '0;
  assign word_last  = word_valid ? last_mem_q[head_q]  : 1'b0;
`ifdef BIT_PACKER_PARITY_EN
  assign word_par   = word_valid ? par_mem_q[head_q]   : 1'b0;
`endif
  assign overflow   = ovf_q;

endmodule
